tl_ul_slave_mem: RTL and testbench

- Parametrised TileLink-UL style slave memory. It is the next generation of the fixed-width slave that sits behind the load/store master.
- Accepts Get, PutFullData and PutPartialData beats on a packed A channel. Performs a single-cycle memory access and queues responses in a credit-limited response FIFO, so D-channel backpressure never drops a beat.
- Flags out-of-range, misaligned and illegal-opcode requests with d_error.

---
 rtl/tl_ul_slave_mem.sv | 173 +++++++++++++++++
 tb/tb_tl_ul_slave_mem.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_slave_mem.sv
// TileLink-UL style slave memory: one-stage request register, single-cycle
// memory access, and an in-order response FIFO guarded by credits.
// Optional feature macro: TL_SLV_ERRCNT_EN adds a saturating err_count output.
module tl_ul_slave_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int SRC_W     = 4,
    parameter int MEM_DEPTH = 256,
    parameter int RSP_DEPTH = 4,
    localparam int A_W = 3 + 2 + SRC_W + ADDR_W + DATA_W/8 + DATA_W,
    localparam int D_W = 3 + 2 + SRC_W + DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [A_W-1:0] a_channel,
    input  logic           a_valid,
    output logic           a_ready,
    output logic [D_W-1:0] d_channel,
    output logic           d_valid,
    input  logic           d_ready,
    output logic           d_error,
    output logic           backpressureslave
`ifdef TL_SLV_ERRCNT_EN
    ,
    output logic [15:0]    err_count
`endif
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [2:0] OP_PUT_FULL  = 3'd0;
    localparam logic [2:0] OP_PUT_PART  = 3'd1;
    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] RSP_ACK      = 3'd0;
    localparam logic [2:0] RSP_ACK_DATA = 3'd1;

    logic [2:0]        a_opcode;
    logic [1:0]        a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [BYTES-1:0]  a_mask;
    logic [DATA_W-1:0] a_data;

    assign {a_opcode, a_size, a_source, a_address, a_mask, a_data} = a_channel;

    logic              stg_valid;
    logic [2:0]        stg_opcode;
    logic [1:0]        stg_size;
    logic [SRC_W-1:0]  stg_source;
    logic [ADDR_W-1:0] stg_addr;
    logic [BYTES-1:0]  stg_mask;
    logic [DATA_W-1:0] stg_data;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [D_W:0]      fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    inflight;

    logic a_acc, push, pop, fifo_full;

    // Credits: stage plus queued responses never exceed the FIFO depth.
    assign inflight          = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(stg_valid);
    assign a_ready           = !reset && (inflight < (CNT_W+1)'(RSP_DEPTH));
    assign backpressureslave = !reset && !a_ready;
    assign a_acc             = a_valid && a_ready;
    assign d_valid           = (fifo_count != '0);
    assign pop               = d_valid && d_ready;
    assign push              = stg_valid;
    assign fifo_full         = (fifo_count == CNT_W'(RSP_DEPTH));

    // Request stage register; every staged beat is serviced the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_valid  <= 1'b0;
            stg_opcode <= '0;
            stg_size   <= '0;
            stg_source <= '0;
            stg_addr   <= '0;
            stg_mask   <= '0;
            stg_data   <= '0;
        end else begin
            stg_valid <= a_acc;
            if (a_acc) begin
                stg_opcode <= a_opcode;
                stg_size   <= a_size;
                stg_source <= a_source;
                stg_addr   <= a_address;
                stg_mask   <= a_mask;
                stg_data   <= a_data;
            end
        end
    end

    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] align_mask;
    logic [MEM_AW-1:0] mem_idx;
    logic              range_err, align_err, size_err, op_err, rsp_err;
    logic              is_get, is_put, wr_en;
    logic [BYTES-1:0]  byte_en;
    logic [DATA_W-1:0] rsp_data;
    logic [2:0]        rsp_opcode;

    assign word_idx   = stg_addr >> OFF_W;
    assign mem_idx    = word_idx[MEM_AW-1:0];
    assign align_mask = ADDR_W'((32'd1 << stg_size) - 32'd1);
    assign range_err  = (32'(word_idx) >= 32'(MEM_DEPTH));
    assign align_err  = |(stg_addr & align_mask);
    assign size_err   = (32'(stg_size) > 32'(OFF_W));
    assign is_get     = (stg_opcode == OP_GET);
    assign is_put     = (stg_opcode == OP_PUT_FULL) || (stg_opcode == OP_PUT_PART);
    assign op_err     = !(is_get || is_put);
    assign rsp_err    = range_err || align_err || size_err || op_err;
    assign wr_en      = stg_valid && is_put && !rsp_err;
    assign byte_en    = (stg_opcode == OP_PUT_FULL) ? '1 : stg_mask;
    // A Get right behind a Put to the same word sees the write because the
    // write lands at the edge that ends the Put's service cycle.
    assign rsp_data   = (is_get && !rsp_err) ? mem[mem_idx] : '0;
    assign rsp_opcode = is_get ? RSP_ACK_DATA : RSP_ACK;

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) mem[mem_idx][b*8 +: 8] <= stg_data[b*8 +: 8];
            end
        end
    end

    // Response FIFO storage; entry = {d_channel, d_error}.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= {rsp_opcode, stg_size, stg_source, rsp_data, rsp_err};
    end

    // FIFO pointers and occupancy; reset drops every queued response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign d_channel = d_valid ? fifo_q[rd_ptr][D_W:1] : '0;
    assign d_error   = d_valid && fifo_q[rd_ptr][0];

    // Credits make a push into a full FIFO impossible; catch it if they break.
    assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

`ifdef TL_SLV_ERRCNT_EN
    // Saturating count of error responses entering the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (push && rsp_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tl_ul_slave_mem.sv
// Directed bench for tl_ul_slave_mem: vector table plus hand-written
// backpressure, steady-state, read-after-write and reset sequences.
module tb_tl_ul_slave_mem;

    localparam int A_W = 3 + 2 + 4 + 16 + 4 + 32;
    localparam int D_W = 3 + 2 + 4 + 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [A_W-1:0] a_channel = '0;
    logic           a_valid = 1'b0;
    logic           a_ready;
    logic [D_W-1:0] d_channel;
    logic           d_valid;
    logic           d_ready = 1'b1;
    logic           d_error;
    logic           backpressureslave;
`ifdef TL_SLV_ERRCNT_EN
    logic [15:0]    err_count;
`endif

    tl_ul_slave_mem dut (
        .clk               (clk),
        .reset             (reset),
        .a_channel         (a_channel),
        .a_valid           (a_valid),
        .a_ready           (a_ready),
        .d_channel         (d_channel),
        .d_valid           (d_valid),
        .d_ready           (d_ready),
        .d_error           (d_error),
        .backpressureslave (backpressureslave)
`ifdef TL_SLV_ERRCNT_EN
        ,
        .err_count         (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  opc;
        logic [1:0]  size;
        logic [3:0]  src;
        logic [15:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  e_opc;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    vec_t gets [6];

    int n_vec = 0;
    int n_bad = 0;
    int last_lat = 0;

    function automatic vec_t mk(input logic [2:0] opc, input logic [1:0] size,
                                input logic [3:0] src, input logic [15:0] addr,
                                input logic [3:0] mask, input logic [31:0] data,
                                input logic [2:0] e_opc, input logic [31:0] e_data,
                                input logic e_err);
        vec_t v;
        v.opc = opc; v.size = size; v.src = src; v.addr = addr; v.mask = mask;
        v.data = data; v.e_opc = e_opc; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [63:0] exp_rsp(input vec_t v);
        return 64'({1'b1, v.e_opc, v.size, v.src, v.e_data, v.e_err});
    endfunction

    function automatic logic [63:0] got_rsp();
        return 64'({d_valid, d_channel, d_error});
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT, got none expected handshake", name);
    endtask

    task automatic drive(input vec_t v);
        a_channel = {v.opc, v.size, v.src, v.addr, v.mask, v.data};
        a_valid   = 1'b1;
    endtask

    // Issue one beat, wait for its response and compare the whole D beat.
    task automatic run_vec(input vec_t v, input string name);
        int guard;
        int lat;
        @(negedge clk);
        drive(v);
        guard = 0;
        while (!a_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!a_ready) begin
            a_valid = 1'b0;
            timeout({name, "_accept"});
            return;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        lat = 1;
        while (!d_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        last_lat = lat;
        check(name, got_rsp(), exp_rsp(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int rx;
        int first_c;
        int last_c;
        logic acc;
        vec_t v;

        vecs[0]  = mk(3'd0, 2'd2, 4'd2,  16'h0010, 4'hF,    32'h0000_0014, 3'd0, 32'h0,          1'b0);
        vecs[1]  = mk(3'd4, 2'd2, 4'd2,  16'h0010, 4'hF,    32'h0,         3'd1, 32'h0000_0014, 1'b0);
        vecs[2]  = mk(3'd1, 2'd2, 4'd3,  16'h0010, 4'b0010, 32'h0000_AB00, 3'd0, 32'h0,          1'b0);
        vecs[3]  = mk(3'd4, 2'd2, 4'd3,  16'h0010, 4'hF,    32'h0,         3'd1, 32'h0000_AB14, 1'b0);
        vecs[4]  = mk(3'd4, 2'd2, 4'd5,  16'h0400, 4'hF,    32'h0,         3'd1, 32'h0,          1'b1);
        vecs[5]  = mk(3'd4, 2'd2, 4'd6,  16'h0002, 4'hF,    32'h0,         3'd1, 32'h0,          1'b1);
        vecs[6]  = mk(3'd3, 2'd2, 4'd4,  16'h0010, 4'hF,    32'h0000_DEAD, 3'd0, 32'h0,          1'b1);
        vecs[7]  = mk(3'd4, 2'd3, 4'd7,  16'h0000, 4'hF,    32'h0,         3'd1, 32'h0,          1'b1);
        vecs[8]  = mk(3'd0, 2'd2, 4'd8,  16'h0400, 4'hF,    32'h0000_1111, 3'd0, 32'h0,          1'b1);
        vecs[9]  = mk(3'd0, 2'd2, 4'd9,  16'h0012, 4'hF,    32'h0000_2222, 3'd0, 32'h0,          1'b1);
        vecs[10] = mk(3'd7, 2'd2, 4'd10, 16'h0010, 4'hF,    32'hFFFF_FFFF, 3'd0, 32'h0,          1'b1);
        vecs[11] = mk(3'd4, 2'd1, 4'd1,  16'h0012, 4'hF,    32'h0,         3'd1, 32'h0000_AB14, 1'b0);
        vecs[12] = mk(3'd0, 2'd2, 4'd11, 16'h03FC, 4'hF,    32'hCAFE_F00D, 3'd0, 32'h0,          1'b0);
        vecs[13] = mk(3'd4, 2'd2, 4'd15, 16'h03FC, 4'hF,    32'h0,         3'd1, 32'hCAFE_F00D, 1'b0);
        vecs[14] = mk(3'd4, 2'd2, 4'd12, 16'h0010, 4'hF,    32'h0,         3'd1, 32'h0000_AB14, 1'b0);
        vecs[15] = mk(3'd1, 2'd2, 4'd13, 16'h03FC, 4'b1001, 32'h1122_3344, 3'd0, 32'h0,          1'b0);
        vecs[16] = mk(3'd4, 2'd2, 4'd14, 16'h03FC, 4'hF,    32'h0,         3'd1, 32'h11FE_F044, 1'b0);
        vecs[17] = mk(3'd4, 2'd0, 4'd6,  16'h0011, 4'hF,    32'h0,         3'd1, 32'h0000_AB14, 1'b0);

        for (int i = 0; i < 6; i++)
            gets[i] = mk(3'd4, 2'd2, 4'(i), 16'(16'h0020 + 4*i), 4'hF, 32'h0,
                         3'd1, 32'(32'hA0 + i), 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({a_ready, d_valid, d_channel, d_error, backpressureslave}), 64'h0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", 64'(a_ready), 64'd1);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) check("latency", 64'(last_lat), 64'd2);
        end

        // Read-after-write with the Get one cycle behind the Put
        run_vec(mk(3'd0, 2'd2, 4'd1, 16'h0040, 4'hF, 32'h11, 3'd0, 32'h0, 1'b0), "raw_pre");
        @(negedge clk);
        check("raw_rdy", 64'(a_ready), 64'd1);
        drive(mk(3'd0, 2'd2, 4'd1, 16'h0040, 4'hF, 32'h55, 3'd0, 32'h0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        drive(mk(3'd4, 2'd2, 4'd2, 16'h0040, 4'hF, 32'h0, 3'd1, 32'h55, 1'b0));
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        rx = 0;
        for (int c = 0; c < 20 && rx < 2; c++) begin
            if (d_valid) begin
                if (rx == 0)
                    check("raw_put", got_rsp(), exp_rsp(mk(3'd0, 2'd2, 4'd1, 16'h0, 4'h0, 32'h0, 3'd0, 32'h0, 1'b0)));
                else
                    check("raw_get", got_rsp(), exp_rsp(mk(3'd4, 2'd2, 4'd2, 16'h0, 4'h0, 32'h0, 3'd1, 32'h55, 1'b0)));
                rx++;
            end
            @(negedge clk);
        end
        if (rx < 2) timeout("raw_rsp");

        // Preload words for the multi-beat sequences
        for (int i = 0; i < 6; i++)
            run_vec(mk(3'd0, 2'd2, 4'd0, gets[i].addr, 4'hF, gets[i].e_data, 3'd0, 32'h0, 1'b0),
                    $sformatf("preload%0d", i));

        // Backpressure: six Gets against a stalled D channel
        @(negedge clk);
        d_ready = 1'b0;
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (issued < 6) drive(gets[issued]); else a_valid = 1'b0;
            acc = a_valid && a_ready;
            @(posedge clk);
            if (acc) issued++;
            @(negedge clk);
        end
        check("bp_accepted", 64'(issued), 64'd4);
        check("bp_flags", 64'({a_ready, backpressureslave, d_valid}), 64'b011);
        d_ready = 1'b1;
        rx = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            if (d_valid) begin
                check($sformatf("bp_rsp%0d", rx), got_rsp(), exp_rsp(gets[rx]));
                rx++;
            end
            if (issued < 6) drive(gets[issued]); else a_valid = 1'b0;
            acc = a_valid && a_ready;
            @(posedge clk);
            if (acc) issued++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        if (rx < 6) timeout("bp_drain");
        check("bp_total_accepted", 64'(issued), 64'd6);

        // Steady state: accept and pop every cycle
        repeat (2) @(negedge clk);
        issued = 0;
        rx = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 30 && rx < 8; c++) begin
            if (d_valid) begin
                check($sformatf("ss_rsp%0d", rx), got_rsp(), exp_rsp(gets[rx % 6]));
                if (first_c < 0) first_c = c;
                last_c = c;
                rx++;
            end
            if (issued < 8) begin
                drive(gets[issued % 6]);
                check($sformatf("ss_ready%0d", issued), 64'(a_ready), 64'd1);
            end else begin
                a_valid = 1'b0;
            end
            acc = a_valid && a_ready;
            @(posedge clk);
            if (acc) issued++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        if (rx < 8) timeout("ss_drain");
        check("ss_one_per_cycle", 64'(last_c - first_c), 64'd7);

        // Reset with three responses buffered
        d_ready = 1'b0;
        issued = 0;
        for (int c = 0; c < 6; c++) begin
            if (issued < 3) drive(gets[issued]); else a_valid = 1'b0;
            acc = a_valid && a_ready;
            @(posedge clk);
            if (acc) issued++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        check("mid_buffered", 64'({d_valid, issued[3:0]}), 64'h13);
        reset = 1'b1;
        #1;
        check("mid_reset_out", 64'({d_valid, a_ready, backpressureslave, d_error, d_channel}), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset", 64'({a_ready, d_valid}), 64'b10);
        d_ready = 1'b1;
`ifdef TL_SLV_ERRCNT_EN
        check("errcnt_reset", 64'(err_count), 64'd0);
`endif
        run_vec(gets[1], "post_reset_get");
        run_vec(vecs[4], "post_err_a");
        run_vec(vecs[5], "post_err_b");
        run_vec(vecs[6], "post_err_c");
        run_vec(vecs[14], "post_mem_kept");
`ifdef TL_SLV_ERRCNT_EN
        check("errcnt_three", 64'(err_count), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
